rggen_register_bus_bridge: RTL and testbench

Host-side stage directly upstream of the per-register blocks. Accepts one host request at a time and drives the shared register bus (valid/access/address/write_data/strobe) to all register instances. Collects their active/ready/status/read_data vectors, resolves a single host response and handles out-of-range, unmapped and stalled accesses.

---
 rtl/rggen_register_bus_bridge_pkg.sv | 35 +++
 rtl/rggen_register_response_mux.sv | 51 +++++
 rtl/rggen_register_bus_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_rggen_register_bus_bridge.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_register_bus_bridge_pkg.sv
// -----------------------------------------------------------------------------
// rggen_register_bus_bridge_pkg
// Shared definitions for the host-side register bus bridge:
//   - access codes driven on the register bus (read / posted write / write)
//   - host response status codes
//   - bridge FSM state encoding
//   - is_write() helper used to suppress read data on write responses
// -----------------------------------------------------------------------------
package rggen_register_bus_bridge_pkg;

  typedef enum logic [1:0] {
    ACCESS_POSTED_WRITE = 2'b01,
    ACCESS_READ         = 2'b10,
    ACCESS_WRITE        = 2'b11
  } access_e;

  typedef enum logic [1:0] {
    STATUS_OKAY         = 2'b00,
    STATUS_EXOKAY       = 2'b01,
    STATUS_SLAVE_ERROR  = 2'b10,
    STATUS_DECODE_ERROR = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'b00,
    STATE_BUSY    = 2'b01,
    STATE_RESPOND = 2'b10
  } state_e;

  // Both write flavours carry a 1 in the LSB of the access code.
  function automatic logic is_write(input logic [1:0] access);
    return access[0];
  endfunction

endpackage

// File: rtl/rggen_register_response_mux.sv
// -----------------------------------------------------------------------------
// rggen_register_response_mux
// Combinational collection of the per-register response vectors. Every
// register whose active bit is clear is masked to zero, then all registers
// are OR-reduced into a single ready/status/read_data response.
// Ports:
//   i_active     per-register address hit
//   i_ready      per-register ready
//   i_status     per-register status, register k at [2k+1:2k]
//   i_read_data  per-register read data, register k at [BUS_WIDTH*k +: BUS_WIDTH]
//   o_active     at least one register hit
//   o_ready      at least one hit register is ready
//   o_status     OR of the hit registers' status
//   o_read_data  OR of the hit registers' read data
// -----------------------------------------------------------------------------
module rggen_register_response_mux #(
  parameter int BUS_WIDTH = 32,
  parameter int REGISTERS = 1
) (
  input  logic [REGISTERS-1:0]           i_active,
  input  logic [REGISTERS-1:0]           i_ready,
  input  logic [2*REGISTERS-1:0]         i_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_read_data,
  output logic                           o_active,
  output logic                           o_ready,
  output logic [1:0]                     o_status,
  output logic [BUS_WIDTH-1:0]           o_read_data
);

  logic [1:0]           status_masked    [REGISTERS];
  logic [BUS_WIDTH-1:0] read_data_masked [REGISTERS];

  for (genvar gi = 0; gi < REGISTERS; gi++) begin : g_mask
    assign status_masked[gi]    = i_status[2*gi+:2] & {2{i_active[gi]}};
    assign read_data_masked[gi] = i_read_data[BUS_WIDTH*gi+:BUS_WIDTH] & {BUS_WIDTH{i_active[gi]}};
  end

  assign o_active = |i_active;
  assign o_ready  = |(i_ready & i_active);

  // Overlapping hits are a map configuration error; they are simply OR-ed.
  always_comb begin
    o_status    = '0;
    o_read_data = '0;
    for (int k = 0; k < REGISTERS; k++) begin
      o_status    = o_status    | status_masked[k];
      o_read_data = o_read_data | read_data_masked[k];
    end
  end

endmodule

// File: rtl/rggen_register_bus_bridge.sv
// -----------------------------------------------------------------------------
// rggen_register_bus_bridge
// Host-side stage in front of the per-register blocks. Accepts one host
// request at a time, drives the shared register bus, and resolves a single
// host response (normal, unmapped, out-of-range decode error, optional stall
// timeout).
// Ports:
//   i_clk / i_rst            clock, asynchronous active-high reset
//   i_host_*                 host request (valid held until o_host_ready)
//   o_host_ready/status/read_data   one-cycle host response
//   o_register_*             registered register bus (valid only while BUSY)
//   i_register_*             per-register active/ready/status/read_data
// Optional feature macro:
//   RGGEN_REGISTER_BUS_TIMEOUT_EN  - when defined, a BUSY stall of
//   TIMEOUT_CYCLES cycles without ready ends with SLAVE_ERROR. When undefined
//   BUSY waits indefinitely and TIMEOUT_CYCLES has no effect.
// -----------------------------------------------------------------------------
module rggen_register_bus_bridge
  import rggen_register_bus_bridge_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH     = 8,
  parameter int                     BUS_WIDTH         = 32,
  parameter int                     REGISTERS         = 1,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS    = '0,
  parameter int                     BYTE_SIZE         = 256,
  parameter bit                     ERROR_STATUS      = 1'b0,
  parameter logic [BUS_WIDTH-1:0]   DEFAULT_READ_DATA = '0,
  parameter int                     TIMEOUT_CYCLES    = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_host_valid,
  input  logic [1:0]                     i_host_access,
  input  logic [ADDRESS_WIDTH-1:0]       i_host_address,
  input  logic [BUS_WIDTH-1:0]           i_host_write_data,
  input  logic [BUS_WIDTH-1:0]           i_host_strobe,
  output logic                           o_host_ready,
  output logic [1:0]                     o_host_status,
  output logic [BUS_WIDTH-1:0]           o_host_read_data,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [ADDRESS_WIDTH-1:0]       o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH-1:0]           o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  if (REGISTERS < 1) begin : g_registers_check
    $error("rggen_register_bus_bridge: REGISTERS must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("rggen_register_bus_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  // One extra bit so BASE_ADDRESS + BYTE_SIZE may reach 2**ADDRESS_WIDTH.
  typedef logic [ADDRESS_WIDTH:0] addr_ext_t;
  localparam addr_ext_t BASE_EXT = {1'b0, BASE_ADDRESS};
  localparam addr_ext_t SIZE_EXT = addr_ext_t'(BYTE_SIZE);

  state_e                 state_q, state_d;
  logic [1:0]             access_q, access_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [BUS_WIDTH-1:0]   write_data_q, write_data_d;
  logic [BUS_WIDTH-1:0]   strobe_q, strobe_d;
  logic                   decode_error_q, decode_error_d;
  logic                   register_valid_q, register_valid_d;
  logic                   host_ready_q, host_ready_d;
  logic [1:0]             host_status_q, host_status_d;
  logic [BUS_WIDTH-1:0]   host_read_data_q, host_read_data_d;

  logic                   any_active;
  logic                   any_ready;
  logic [1:0]             mux_status;
  logic [BUS_WIDTH-1:0]   mux_read_data;
  logic                   timeout;
  addr_ext_t              offset_ext;
  logic                   in_range;

  rggen_register_response_mux #(
    .BUS_WIDTH (BUS_WIDTH),
    .REGISTERS (REGISTERS)
  ) u_response_mux (
    .i_active    (i_register_active),
    .i_ready     (i_register_ready),
    .i_status    (i_register_status),
    .i_read_data (i_register_read_data),
    .o_active    (any_active),
    .o_ready     (any_ready),
    .o_status    (mux_status),
    .o_read_data (mux_read_data)
  );

  // An address below the base borrows into the extra MSB of the difference.
  assign offset_ext = {1'b0, i_host_address} - BASE_EXT;
  assign in_range   = !offset_ext[ADDRESS_WIDTH] && (offset_ext < SIZE_EXT);

`ifdef RGGEN_REGISTER_BUS_TIMEOUT_EN
  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  typedef logic [TIMER_WIDTH-1:0] timer_t;

  timer_t timer_q, timer_d;

  // Zero in every non-BUSY state, so each BUSY entry starts from zero.
  assign timer_d = (state_q == STATE_BUSY) ? timer_q + 1'b1 : '0;
  assign timeout = (state_q == STATE_BUSY) && (timer_q == timer_t'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    access_d         = access_q;
    address_d        = address_q;
    write_data_d     = write_data_q;
    strobe_d         = strobe_q;
    decode_error_d   = decode_error_q;
    register_valid_d = register_valid_q;
    host_ready_d     = 1'b0;
    host_status_d    = host_status_q;
    host_read_data_d = host_read_data_q;

    case (state_q)
      STATE_IDLE: begin
        host_status_d    = '0;
        host_read_data_d = '0;
        if (i_host_valid) begin
          access_d       = i_host_access;
          address_d      = offset_ext[ADDRESS_WIDTH-1:0];
          write_data_d   = i_host_write_data;
          strobe_d       = i_host_strobe;
          // Out-of-range requests still spend one cycle in BUSY, with the
          // register bus kept quiet, so every response arrives two cycles
          // after the request at the earliest.
          decode_error_d   = !in_range;
          register_valid_d = in_range;
          state_d          = STATE_BUSY;
        end
      end

      STATE_BUSY: begin
        if (decode_error_q) begin
          host_ready_d     = 1'b1;
          host_status_d    = STATUS_DECODE_ERROR;
          host_read_data_d = DEFAULT_READ_DATA;
        end else if (any_active && any_ready) begin
          // Ready beats a timeout expiring in the same cycle.
          host_ready_d     = 1'b1;
          host_status_d    = mux_status;
          host_read_data_d = mux_read_data;
        end else if (!any_active) begin
          host_ready_d     = 1'b1;
          host_status_d    = ERROR_STATUS ? STATUS_SLAVE_ERROR : STATUS_OKAY;
          host_read_data_d = DEFAULT_READ_DATA;
        end else if (timeout) begin
          host_ready_d     = 1'b1;
          host_status_d    = STATUS_SLAVE_ERROR;
          host_read_data_d = DEFAULT_READ_DATA;
        end

        if (host_ready_d) begin
          if (is_write(access_q)) begin
            host_read_data_d = '0;
          end
          decode_error_d   = 1'b0;
          register_valid_d = 1'b0;
          state_d          = STATE_RESPOND;
        end
      end

      STATE_RESPOND: begin
        state_d = STATE_IDLE;
      end

      default: begin
        state_d          = STATE_IDLE;
        register_valid_d = 1'b0;
        decode_error_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q          <= STATE_IDLE;
      access_q         <= '0;
      address_q        <= '0;
      write_data_q     <= '0;
      strobe_q         <= '0;
      decode_error_q   <= 1'b0;
      register_valid_q <= 1'b0;
      host_ready_q     <= 1'b0;
      host_status_q    <= '0;
      host_read_data_q <= '0;
    end else begin
      state_q          <= state_d;
      access_q         <= access_d;
      address_q        <= address_d;
      write_data_q     <= write_data_d;
      strobe_q         <= strobe_d;
      decode_error_q   <= decode_error_d;
      register_valid_q <= register_valid_d;
      host_ready_q     <= host_ready_d;
      host_status_q    <= host_status_d;
      host_read_data_q <= host_read_data_d;
    end
  end

  assign o_host_ready          = host_ready_q;
  assign o_host_status         = host_status_q;
  assign o_host_read_data      = host_read_data_q;
  assign o_register_valid      = register_valid_q;
  assign o_register_access     = access_q;
  assign o_register_address    = address_q;
  assign o_register_write_data = write_data_q;
  assign o_register_strobe     = strobe_q;

endmodule

// File: tb/tb_rggen_register_bus_bridge.sv
module tb_rggen_register_bus_bridge;

  localparam logic [31:0] D0_DEF = 32'hBAD0_BAD0;
  localparam logic [31:0] D1_DEF = 32'h5A5A_A5A5;
  localparam int          TMO    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  host_valid;
  logic [1:0]  host_access;
  logic [11:0] host_address;
  logic [31:0] host_wdata;
  logic [31:0] host_strobe;
  logic [1:0]  reg_active;
  logic [1:0]  reg_ready;
  logic [3:0]  reg_status;
  logic [63:0] reg_rdata;

  logic        d0_ready, d1_ready, d0_rvalid, d1_rvalid;
  logic [1:0]  d0_status, d1_status, d0_racc, d1_racc;
  logic [31:0] d0_rdata, d1_rdata, d0_rwdata, d1_rwdata, d0_rstrobe, d1_rstrobe;
  logic [7:0]  d0_raddr;
  logic [11:0] d1_raddr;

  int          cur_sel;
  logic        m_ready, m_rvalid;
  logic [1:0]  m_status, m_racc;
  logic [31:0] m_rdata, m_rwdata, m_rstrobe;
  logic [11:0] m_raddr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rggen_register_bus_bridge #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTERS(2), .BASE_ADDRESS(8'h00),
    .BYTE_SIZE(256), .ERROR_STATUS(1'b0), .DEFAULT_READ_DATA(D0_DEF), .TIMEOUT_CYCLES(TMO)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .i_host_valid(host_valid[0]), .i_host_access(host_access),
    .i_host_address(host_address[7:0]), .i_host_write_data(host_wdata), .i_host_strobe(host_strobe),
    .o_host_ready(d0_ready), .o_host_status(d0_status), .o_host_read_data(d0_rdata),
    .o_register_valid(d0_rvalid), .o_register_access(d0_racc), .o_register_address(d0_raddr),
    .o_register_write_data(d0_rwdata), .o_register_strobe(d0_rstrobe),
    .i_register_active(reg_active), .i_register_ready(reg_ready),
    .i_register_status(reg_status), .i_register_read_data(reg_rdata)
  );

  rggen_register_bus_bridge #(
    .ADDRESS_WIDTH(12), .BUS_WIDTH(32), .REGISTERS(2), .BASE_ADDRESS(12'h100),
    .BYTE_SIZE(64), .ERROR_STATUS(1'b1), .DEFAULT_READ_DATA(D1_DEF), .TIMEOUT_CYCLES(TMO)
  ) dut1 (
    .i_clk(clk), .i_rst(rst), .i_host_valid(host_valid[1]), .i_host_access(host_access),
    .i_host_address(host_address), .i_host_write_data(host_wdata), .i_host_strobe(host_strobe),
    .o_host_ready(d1_ready), .o_host_status(d1_status), .o_host_read_data(d1_rdata),
    .o_register_valid(d1_rvalid), .o_register_access(d1_racc), .o_register_address(d1_raddr),
    .o_register_write_data(d1_rwdata), .o_register_strobe(d1_rstrobe),
    .i_register_active(reg_active), .i_register_ready(reg_ready),
    .i_register_status(reg_status), .i_register_read_data(reg_rdata)
  );

  always_comb begin
    if (cur_sel == 1) begin
      m_ready = d1_ready; m_status = d1_status; m_rdata = d1_rdata; m_rvalid = d1_rvalid;
      m_racc = d1_racc; m_raddr = d1_raddr; m_rwdata = d1_rwdata; m_rstrobe = d1_rstrobe;
    end else begin
      m_ready = d0_ready; m_status = d0_status; m_rdata = d0_rdata; m_rvalid = d0_rvalid;
      m_racc = d0_racc; m_raddr = {4'h0, d0_raddr}; m_rwdata = d0_rwdata; m_rstrobe = d0_rstrobe;
    end
  end

  // Reference model: response predicted from the address map and the
  // register-side behaviour chosen for the transaction.
  function automatic void model(input int sel, input logic [1:0] acc, input logic [11:0] addr,
                                input logic [1:0] act, input int delay,
                                output int lat, output logic [1:0] st, output logic [31:0] rd,
                                output int rvc);
    int          base = (sel == 1) ? 'h100 : 0;
    int          size = (sel == 1) ? 64 : 256;
    bit          errs = (sel == 1);
    logic [31:0] def  = (sel == 1) ? D1_DEF : D0_DEF;
    bit          wr   = (acc == 2'b01) || (acc == 2'b11);
    if (int'(addr) < base || int'(addr) >= base + size) begin
      lat = 2; st = 2'b11; rd = wr ? 32'h0 : def; rvc = 0;
    end else if (act == 2'b00) begin
      lat = 2; st = errs ? 2'b10 : 2'b00; rd = wr ? 32'h0 : def; rvc = 1;
    end else begin
      lat = delay + 2; rvc = delay + 1; st = 2'b00; rd = 32'h0;
      for (int k = 0; k < 2; k++) begin
        if (act[k]) begin
          st = st | reg_status[2*k+:2];
          if (!wr) rd = rd | reg_rdata[32*k+:32];
        end
      end
    end
  endfunction

  // Drives one host request and reports what the selected bridge did.
  // Active registers raise ready once they have seen delay+1 bus cycles;
  // inactive registers keep ready high throughout.
  task automatic run_txn(input int sel, input logic [1:0] acc, input logic [11:0] addr,
                         input logic [11:0] eoff, input logic [31:0] wdata, input logic [31:0] strobe,
                         input logic [1:0] act, input int delay, input int budget,
                         output int lat, output logic [1:0] st, output logic [31:0] rd,
                         output int rvc, output int bad, output bit extra);
    cur_sel = sel;
    @(negedge clk);
    reg_active   = act;
    reg_ready    = ~act;
    host_access  = acc;
    host_address = addr;
    host_wdata   = wdata;
    host_strobe  = strobe;
    host_valid   = 2'b00;
    host_valid[sel] = 1'b1;
    lat = -1; st = 2'b00; rd = 32'h0; rvc = 0; bad = 0; extra = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (m_rvalid) begin
        rvc++;
        if (m_racc !== acc || m_raddr !== eoff || m_rwdata !== wdata || m_rstrobe !== strobe) bad++;
      end
      if (m_ready) begin
        lat = c; st = m_status; rd = m_rdata;
        if (m_rvalid) bad++;
        break;
      end
      reg_ready = ~act | ((rvc >= delay + 1) ? act : 2'b00);
    end
    host_valid = 2'b00;
    reg_ready  = 2'b00;
    @(posedge clk); #1;
    extra = m_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    host_valid = 2'b00; host_access = 2'b00; host_address = '0; host_wdata = '0; host_strobe = '0;
    reg_active = '0; reg_ready = '0; reg_status = '0; reg_rdata = '0; cur_sel = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({d0_ready, d0_status, d0_rdata, d0_rvalid, d0_racc, d0_raddr, d0_rwdata, d0_rstrobe} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut0: got ready=%b status=%b rvalid=%b addr=%h, required all zero",
               d0_ready, d0_status, d0_rvalid, d0_raddr);
    end
    n_checks++;
    if ({d1_ready, d1_status, d1_rdata, d1_rvalid, d1_racc, d1_raddr, d1_rwdata, d1_rstrobe} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut1: got ready=%b status=%b rvalid=%b addr=%h, required all zero",
               d1_ready, d1_status, d1_rvalid, d1_raddr);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("txn reset: outputs checked after reset");
  endtask

  task automatic test_read_basic();
    int lat, rvc, bad; logic [1:0] st; logic [31:0] rd; bit extra;
    reg_status = 4'b00_01;
    reg_rdata  = {32'hDEADBEEF, 32'h1111_1111};
    run_txn(0, 2'b10, 12'h004, 12'h004, 32'h0, 32'h0, 2'b10, 0, 20, lat, st, rd, rvc, bad, extra);
    $display("txn read_basic: lat=%0d status=%b data=%h", lat, st, rd);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL read_basic_latency: got %0d required 2", lat); end
    n_checks++; if (st !== 2'b00) begin n_fail++; $display("FAIL read_basic_status: got %b required 00", st); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_basic_data: got %h required deadbeef", rd); end
    n_checks++; if (rvc !== 1) begin n_fail++; $display("FAIL read_basic_valid_cycles: got %0d required 1", rvc); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL read_basic_bus: got %0d bad cycles required 0", bad); end
    n_checks++; if (extra !== 1'b0) begin n_fail++; $display("FAIL read_basic_single_pulse: got %b required 0", extra); end
  endtask

  task automatic test_write_wait();
    int lat, rvc, bad; logic [1:0] st; logic [31:0] rd; bit extra;
    reg_status = 4'b11_00;
    reg_rdata  = {32'h7777_7777, 32'hCAFEF00D};
    run_txn(0, 2'b11, 12'h000, 12'h000, 32'h12345678, 32'h0000FFFF, 2'b01, 3, 30,
            lat, st, rd, rvc, bad, extra);
    $display("txn write_wait: lat=%0d status=%b data=%h valid_cycles=%0d", lat, st, rd, rvc);
    n_checks++; if (rvc !== 4) begin n_fail++; $display("FAIL write_wait_valid_cycles: got %0d required 4", rvc); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL write_wait_latency: got %0d required 5", lat); end
    n_checks++; if (st !== 2'b00) begin n_fail++; $display("FAIL write_wait_status: got %b required 00", st); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL write_wait_data: got %h required 0", rd); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL write_wait_bus: got %0d bad cycles required 0", bad); end
  endtask

  task automatic test_decode_error();
    int lat, rvc, bad; logic [1:0] st; logic [31:0] rd; bit extra;
    logic [11:0] addrs [3] = '{12'h140, 12'h0FF, 12'h13F};
    reg_status = 4'b01_01;
    reg_rdata  = {32'h2222_2222, 32'h3333_3333};
    for (int i = 0; i < 3; i++) begin
      bit inr = (addrs[i] == 12'h13F);
      run_txn(1, 2'b10, addrs[i], addrs[i] - 12'h100, 32'h0, 32'h0, 2'b01, 0, 20,
              lat, st, rd, rvc, bad, extra);
      $display("txn decode addr=%h: lat=%0d status=%b data=%h valid_cycles=%0d", addrs[i], lat, st, rd, rvc);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL decode_latency: addr %h got %0d required 2", addrs[i], lat); end
      n_checks++;
      if (st !== (inr ? 2'b01 : 2'b11)) begin
        n_fail++; $display("FAIL decode_status: addr %h got %b required %b", addrs[i], st, inr ? 2'b01 : 2'b11);
      end
      n_checks++;
      if (rd !== (inr ? 32'h3333_3333 : D1_DEF)) begin
        n_fail++; $display("FAIL decode_data: addr %h got %h required %h", addrs[i], rd, inr ? 32'h3333_3333 : D1_DEF);
      end
      n_checks++;
      if (rvc !== (inr ? 1 : 0)) begin
        n_fail++; $display("FAIL decode_valid_cycles: addr %h got %0d required %0d", addrs[i], rvc, inr ? 1 : 0);
      end
    end
  endtask

  task automatic test_unmapped();
    int lat, rvc, bad; logic [1:0] st; logic [31:0] rd; bit extra;
    reg_status = 4'b01_01;
    reg_rdata  = {32'h4444_4444, 32'h5555_5555};
    run_txn(1, 2'b10, 12'h120, 12'h020, 32'h0, 32'h0, 2'b00, 0, 20, lat, st, rd, rvc, bad, extra);
    $display("txn unmapped err=1: lat=%0d status=%b data=%h", lat, st, rd);
    n_checks++; if (st !== 2'b10) begin n_fail++; $display("FAIL unmapped1_status: got %b required 10", st); end
    n_checks++; if (rd !== D1_DEF) begin n_fail++; $display("FAIL unmapped1_data: got %h required %h", rd, D1_DEF); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL unmapped1_latency: got %0d required 2", lat); end
    run_txn(0, 2'b10, 12'h010, 12'h010, 32'h0, 32'h0, 2'b00, 0, 20, lat, st, rd, rvc, bad, extra);
    $display("txn unmapped err=0: lat=%0d status=%b data=%h", lat, st, rd);
    n_checks++; if (st !== 2'b00) begin n_fail++; $display("FAIL unmapped0_status: got %b required 00", st); end
    n_checks++; if (rd !== D0_DEF) begin n_fail++; $display("FAIL unmapped0_data: got %h required %h", rd, D0_DEF); end
  endtask

  task automatic test_stall();
    int lat, rvc, bad; logic [1:0] st; logic [31:0] rd; bit extra;
    reg_status = 4'b10_00;
    reg_rdata  = {32'h6666_6666, 32'h0BAD_CAFE};
`ifdef RGGEN_REGISTER_BUS_TIMEOUT_EN
    run_txn(0, 2'b10, 12'h020, 12'h020, 32'h0, 32'h0, 2'b01, 1000, 40, lat, st, rd, rvc, bad, extra);
    $display("txn timeout: lat=%0d status=%b data=%h valid_cycles=%0d", lat, st, rd, rvc);
    n_checks++; if (lat !== TMO + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d required %0d", lat, TMO + 1); end
    n_checks++; if (st !== 2'b10) begin n_fail++; $display("FAIL timeout_status: got %b required 10", st); end
    n_checks++; if (rd !== D0_DEF) begin n_fail++; $display("FAIL timeout_data: got %h required %h", rd, D0_DEF); end
    n_checks++; if (rvc !== TMO) begin n_fail++; $display("FAIL timeout_valid_cycles: got %0d required %0d", rvc, TMO); end
    run_txn(0, 2'b10, 12'h020, 12'h020, 32'h0, 32'h0, 2'b01, TMO - 1, 40, lat, st, rd, rvc, bad, extra);
    $display("txn ready_at_expiry: lat=%0d status=%b data=%h", lat, st, rd);
    n_checks++; if (lat !== TMO + 1) begin n_fail++; $display("FAIL expiry_latency: got %0d required %0d", lat, TMO + 1); end
    n_checks++; if (st !== 2'b00) begin n_fail++; $display("FAIL expiry_status: got %b required 00", st); end
    n_checks++; if (rd !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL expiry_data: got %h required 0badcafe", rd); end
`else
    run_txn(0, 2'b10, 12'h020, 12'h020, 32'h0, 32'h0, 2'b01, 30, 60, lat, st, rd, rvc, bad, extra);
    $display("txn long_stall: lat=%0d status=%b data=%h valid_cycles=%0d", lat, st, rd, rvc);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL stall_latency: got %0d required 32", lat); end
    n_checks++; if (st !== 2'b00) begin n_fail++; $display("FAIL stall_status: got %b required 00", st); end
    n_checks++; if (rd !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL stall_data: got %h required 0badcafe", rd); end
    n_checks++; if (rvc !== 31) begin n_fail++; $display("FAIL stall_valid_cycles: got %0d required 31", rvc); end
`endif
  endtask

  task automatic test_reset_mid();
    int lat, rvc, bad; logic [1:0] st; logic [31:0] rd; bit extra;
    bit seen;
    cur_sel = 0;
    @(negedge clk);
    reg_active = 2'b01; reg_ready = 2'b10;
    host_access = 2'b10; host_address = 12'h030; host_valid = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (d0_rvalid !== 1'b1) begin n_fail++; $display("FAIL mid_reset_busy: got rvalid %b required 1", d0_rvalid); end
    @(negedge clk);
    rst = 1'b1;
    host_valid = 2'b00;
    #1;
    n_checks++;
    if ({d0_ready, d0_status, d0_rdata, d0_rvalid, d0_racc, d0_raddr, d0_rwdata, d0_rstrobe} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got ready=%b rvalid=%b acc=%b addr=%h required all zero",
               d0_ready, d0_rvalid, d0_racc, d0_raddr);
    end
    @(negedge clk);
    rst = 1'b0;
    reg_ready = 2'b11;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (d0_ready || d0_rvalid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_response: got activity %b required 0", seen); end
    reg_status = 4'b00_00;
    reg_rdata  = {32'h0, 32'hFEED_0001};
    run_txn(0, 2'b10, 12'h030, 12'h030, 32'h0, 32'h0, 2'b01, 1, 20, lat, st, rd, rvc, bad, extra);
    $display("txn after_reset: lat=%0d status=%b data=%h", lat, st, rd);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL after_reset_latency: got %0d required 3", lat); end
    n_checks++; if (rd !== 32'hFEED_0001) begin n_fail++; $display("FAIL after_reset_data: got %h required feed0001", rd); end
  endtask

  task automatic test_random();
    int lat, rvc, bad, elat, ervc, sel, delay;
    logic [1:0] st, est, acc, act;
    logic [31:0] rd, erd;
    logic [11:0] addr, eoff;
    bit extra, inr;
    for (int t = 0; t < 40; t++) begin
      sel   = int'($urandom_range(0, 1));
      act   = 2'($urandom_range(0, 3));
      delay = int'($urandom_range(0, 5));
      addr  = (sel == 1) ? 12'($urandom_range('h0F0, 'h150)) : 12'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0:       acc = 2'b10;
        1:       acc = 2'b01;
        default: acc = 2'b11;
      endcase
      inr = (sel == 0) || (addr >= 12'h100 && addr < 12'h140);
      if (!inr || act == 2'b00) acc = 2'b10;
      reg_status = 4'($urandom);
      reg_rdata  = {$urandom, $urandom};
      eoff = (sel == 1) ? addr - 12'h100 : addr;
      model(sel, acc, addr, act, delay, elat, est, erd, ervc);
      run_txn(sel, acc, addr, eoff, $urandom, $urandom, act, delay, 30, lat, st, rd, rvc, bad, extra);
      $display("txn rand %0d: dut%0d acc=%b addr=%h act=%b delay=%0d lat=%0d status=%b data=%h",
               t, sel, acc, addr, act, delay, lat, st, rd);
      n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL rand_latency %0d: got %0d required %0d", t, lat, elat); end
      n_checks++; if (st !== est) begin n_fail++; $display("FAIL rand_status %0d: got %b required %b", t, st, est); end
      n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL rand_data %0d: got %h required %h", t, rd, erd); end
      n_checks++; if (rvc !== ervc) begin n_fail++; $display("FAIL rand_valid_cycles %0d: got %0d required %0d", t, rvc, ervc); end
      n_checks++; if (bad !== 0 || extra !== 1'b0) begin
        n_fail++; $display("FAIL rand_bus %0d: got bad=%0d extra=%b required 0/0", t, bad, extra);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_wait();
    test_decode_error();
    test_unmapped();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
